chip8_ram_arbiter: RTL and testbench

Shares the single-port 4096×8 Chip-8 program/data RAM between three requesters: the CPU core, the sprite engine (DXYN row reads), and the ROM loader (image writes).

- Arbitrates one RAM access per cycle, round-robin.
- Supports bounded burst locking, so a two-byte opcode fetch or an N-row sprite read completes uninterrupted.
- Returns read data with fixed latency, tagged to the requester that issued it.

---
 rtl/chip8_ram_arbiter.sv | 200 ++++++++++++++++++++
 tb/tb_chip8_ram_arbiter.sv | 331 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/chip8_ram_arbiter.sv
// Shares the single-port Chip-8 RAM between cpu, sprite engine and ROM loader:
// round-robin grant with bounded burst locking and a fixed two-cycle tagged read return.
module chip8_ram_arbiter #(
  parameter int ADDR_W   = 12,
  parameter int DATA_W   = 8,
  parameter int LOCK_MAX = 16
) (
  input  logic              clk,
  input  logic              reset,

  input  logic              cpu_req,
  input  logic              cpu_lock,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_gnt,
  output logic              cpu_rvalid,

  input  logic              spr_req,
  input  logic              spr_lock,
  input  logic              spr_we,
  input  logic [ADDR_W-1:0] spr_addr,
  input  logic [DATA_W-1:0] spr_wdata,
  output logic              spr_gnt,
  output logic              spr_rvalid,

  input  logic              ldr_req,
  input  logic              ldr_lock,
  input  logic              ldr_we,
  input  logic [ADDR_W-1:0] ldr_addr,
  input  logic [DATA_W-1:0] ldr_wdata,
  output logic              ldr_gnt,
  output logic              ldr_rvalid,

  output logic [DATA_W-1:0] rdata,

  output logic              ram_en,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata,

  output logic [1:0]        owner
);

  localparam logic [1:0] ID_CPU   = 2'd0;
  localparam logic [1:0] ID_SPR   = 2'd1;
  localparam logic [1:0] ID_LDR   = 2'd2;
  localparam logic [7:0] LOCK_LIM = 8'(LOCK_MAX);

  logic [1:0]        last;
  logic              lock_vld;
  logic [1:0]        lock_own;
  logic [7:0]        lock_cnt;

  logic              p1_vld, p2_vld;
  logic [1:0]        p1_id, p2_id;

  logic [2:0]        req;
  logic [2:0]        cand;
  logic              own_act, own_cap;
  logic [1:0]        p0, p1, p2;
  logic              win_vld;
  logic [1:0]        win;
  logic              win_we, win_lock;
  logic [ADDR_W-1:0] win_addr;
  logic [DATA_W-1:0] win_wdata;

  function automatic logic [1:0] rr_next(input logic [1:0] id);
    logic [1:0] nxt;
    nxt = (id == ID_LDR) ? ID_CPU : id + 2'd1;
    return nxt;
  endfunction

  function automatic logic bit_of(input logic [2:0] v, input logic [1:0] id);
    logic b;
    case (id)
      ID_CPU:  b = v[0];
      ID_SPR:  b = v[1];
      ID_LDR:  b = v[2];
      default: b = 1'b0;
    endcase
    return b;
  endfunction

  function automatic logic [2:0] onehot(input logic [1:0] id);
    logic [2:0] oh;
    case (id)
      ID_CPU:  oh = 3'b001;
      ID_SPR:  oh = 3'b010;
      ID_LDR:  oh = 3'b100;
      default: oh = 3'b000;
    endcase
    return oh;
  endfunction

  assign req = {ldr_req, spr_req, cpu_req};

  always_comb begin
    own_act = lock_vld && bit_of(req, lock_own);
    own_cap = own_act && (lock_cnt == LOCK_LIM);
    // At the lock bound the owner sits out one arbitration, unless nobody else wants the RAM.
    cand    = own_cap ? (req & ~onehot(lock_own)) : req;
    p0      = rr_next(last);
    p1      = rr_next(p0);
    p2      = last;
    win_vld = 1'b0;
    win     = ID_CPU;
    if (own_act && !(own_cap && (cand != 3'b000))) begin
      win_vld = 1'b1;
      win     = lock_own;
    end else if (bit_of(cand, p0)) begin
      win_vld = 1'b1;
      win     = p0;
    end else if (bit_of(cand, p1)) begin
      win_vld = 1'b1;
      win     = p1;
    end else if (bit_of(cand, p2)) begin
      win_vld = 1'b1;
      win     = p2;
    end
    if (!reset) begin
      win_vld = 1'b0;
    end

    win_we    = ldr_we;
    win_lock  = ldr_lock;
    win_addr  = ldr_addr;
    win_wdata = ldr_wdata;
    case (win)
      ID_CPU: begin
        win_we    = cpu_we;
        win_lock  = cpu_lock;
        win_addr  = cpu_addr;
        win_wdata = cpu_wdata;
      end
      ID_SPR: begin
        win_we    = spr_we;
        win_lock  = spr_lock;
        win_addr  = spr_addr;
        win_wdata = spr_wdata;
      end
      default: ;
    endcase
  end

  assign cpu_gnt = win_vld && (win == ID_CPU);
  assign spr_gnt = win_vld && (win == ID_SPR);
  assign ldr_gnt = win_vld && (win == ID_LDR);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      last      <= ID_LDR;
      lock_vld  <= 1'b0;
      lock_own  <= ID_CPU;
      lock_cnt  <= 8'd0;
      ram_en    <= 1'b0;
      ram_we    <= 1'b0;
      ram_addr  <= '0;
      ram_wdata <= '0;
      p1_vld    <= 1'b0;
      p1_id     <= ID_CPU;
      p2_vld    <= 1'b0;
      p2_id     <= ID_CPU;
    end else begin
      ram_en <= win_vld;
      p1_vld <= win_vld && !win_we;
      p1_id  <= win;
      p2_vld <= p1_vld;
      p2_id  <= p1_id;
      if (win_vld) begin
        last      <= win;
        ram_we    <= win_we;
        ram_addr  <= win_addr;
        ram_wdata <= win_wdata;
        if (win_lock) begin
          lock_vld <= 1'b1;
          lock_own <= win;
          // A grant after the bound (owner alone) starts a fresh run of LOCK_MAX.
          lock_cnt <= (own_act && (win == lock_own) && (lock_cnt != LOCK_LIM))
                      ? lock_cnt + 8'd1 : 8'd1;
        end else begin
          lock_vld <= 1'b0;
          lock_cnt <= 8'd0;
        end
      end else begin
        ram_we   <= 1'b0;
        lock_vld <= 1'b0;
        lock_cnt <= 8'd0;
      end
    end
  end

  assign cpu_rvalid = p2_vld && (p2_id == ID_CPU);
  assign spr_rvalid = p2_vld && (p2_id == ID_SPR);
  assign ldr_rvalid = p2_vld && (p2_id == ID_LDR);
  assign rdata      = ram_rdata;
  assign owner      = last;

endmodule

// File: tb/tb_chip8_ram_arbiter.sv
// Randomized scoreboard bench for chip8_ram_arbiter: a rule-level arbitration model predicts
// every grant, and a monitor matches tagged read returns against a reference memory.
module tb_chip8_ram_arbiter;

  localparam int LOCK_MAX = 16;

  logic        clk;
  logic        reset;
  logic [2:0]  req_v, lock_v, we_v;
  logic [11:0] addr_v [3];
  logic [7:0]  wd_v [3];

  logic        cpu_gnt, spr_gnt, ldr_gnt;
  logic        cpu_rvalid, spr_rvalid, ldr_rvalid;
  logic [7:0]  rdata;
  logic        ram_en, ram_we;
  logic [11:0] ram_addr;
  logic [7:0]  ram_wdata;
  logic [7:0]  ram_rdata;
  logic [1:0]  owner;

  chip8_ram_arbiter #(.ADDR_W(12), .DATA_W(8), .LOCK_MAX(LOCK_MAX)) dut (
    .clk(clk), .reset(reset),
    .cpu_req(req_v[0]), .cpu_lock(lock_v[0]), .cpu_we(we_v[0]), .cpu_addr(addr_v[0]),
    .cpu_wdata(wd_v[0]), .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid),
    .spr_req(req_v[1]), .spr_lock(lock_v[1]), .spr_we(we_v[1]), .spr_addr(addr_v[1]),
    .spr_wdata(wd_v[1]), .spr_gnt(spr_gnt), .spr_rvalid(spr_rvalid),
    .ldr_req(req_v[2]), .ldr_lock(lock_v[2]), .ldr_we(we_v[2]), .ldr_addr(addr_v[2]),
    .ldr_wdata(wd_v[2]), .ldr_gnt(ldr_gnt), .ldr_rvalid(ldr_rvalid),
    .rdata(rdata),
    .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
    .ram_rdata(ram_rdata),
    .owner(owner)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous single-port RAM attached to the arbiter.
  logic [7:0] mem [4096];
  always @(posedge clk) begin
    if (ram_en) begin
      if (ram_we) mem[ram_addr] <= ram_wdata;
      else        ram_rdata <= mem[ram_addr];
    end
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Reference state: memory contents, arbitration history, expected read returns.
  typedef struct { int id; logic [7:0] data; int cyc; } exp_t;
  exp_t       sb[$];
  logic [7:0] ref_mem [4096];
  int         m_last;
  int         lk_who;
  int         lk_n;
  bit         m_prev_g;
  logic [11:0] m_prev_addr;
  logic       m_prev_we;
  logic [7:0] m_prev_wd;
  logic [2:0] g_seen;

  function automatic int model_pick();
    int  order [3];
    bit  others;
    for (int k = 0; k < 3; k++) order[k] = (m_last + 1 + k) % 3;
    if (lk_who >= 0 && req_v[lk_who]) begin
      others = 0;
      for (int k = 0; k < 3; k++) if (k != lk_who && req_v[k]) others = 1;
      if (lk_n < LOCK_MAX || !others) return lk_who;
      for (int k = 0; k < 3; k++)
        if (order[k] != lk_who && req_v[order[k]]) return order[k];
    end
    for (int k = 0; k < 3; k++) if (req_v[order[k]]) return order[k];
    return -1;
  endfunction

  task automatic model_commit(input int w);
    if (w < 0) begin
      lk_who   = -1;
      lk_n     = 0;
      m_prev_g = 0;
      return;
    end
    if (!we_v[w]) sb.push_back('{w, ref_mem[addr_v[w]], cyc + 2});
    else          ref_mem[addr_v[w]] = wd_v[w];
    m_prev_g    = 1;
    m_prev_addr = addr_v[w];
    m_prev_we   = we_v[w];
    m_prev_wd   = wd_v[w];
    m_last      = w;
    if (lock_v[w]) begin
      lk_n   = (lk_who == w && lk_n < LOCK_MAX) ? lk_n + 1 : 1;
      lk_who = w;
    end else begin
      lk_who = -1;
      lk_n   = 0;
    end
  endtask

  task automatic model_reset();
    sb.delete();
    m_last   = 2;
    lk_who   = -1;
    lk_n     = 0;
    m_prev_g = 0;
  endtask

  // One clock cycle: inputs already driven; checks at the falling edge, returns 1 after the next rising edge.
  task automatic cycle_step();
    logic [2:0] g, eg;
    int w;
    @(negedge clk);
    g = {ldr_gnt, spr_gnt, cpu_gnt};
    chk("owner", 32'(owner), 32'(m_last));
    chk("ram_en", 32'(ram_en), 32'(m_prev_g));
    if (m_prev_g) begin
      chk("ram_addr", 32'(ram_addr), 32'(m_prev_addr));
      chk("ram_we", 32'(ram_we), 32'(m_prev_we));
      if (m_prev_we) chk("ram_wdata", 32'(ram_wdata), 32'(m_prev_wd));
    end
    w  = reset ? model_pick() : -1;
    eg = (w < 0) ? 3'b000 : 3'(3'b001 << w);
    chk("gnt", 32'(g), 32'(eg));
    g_seen = g;
    if (reset) model_commit(w);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input int hold);
    reset = 1'b0;
    model_reset();
    repeat (hold) cycle_step();
    reset = 1'b1;
  endtask

  // Monitor: every rvalid must match the oldest outstanding read, exactly on its due cycle.
  always @(negedge clk) begin
    logic [2:0] rv;
    exp_t e;
    rv = {ldr_rvalid, spr_rvalid, cpu_rvalid};
    if (rv != 3'b000) begin
      if (sb.size() == 0) begin
        chk("rvalid_spurious", 32'(rv), 32'd0);
      end else begin
        e = sb.pop_front();
        chk("rvalid_id", 32'(rv), 32'(3'b001 << e.id));
        chk("rdata", 32'(rdata), 32'(e.data));
        chk("rvalid_latency", 32'(cyc), 32'(e.cyc));
      end
    end else if (sb.size() != 0 && sb[0].cyc <= cyc) begin
      e = sb.pop_front();
      chk("rvalid_missing", 32'(rv), 32'(3'b001 << e.id));
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int  n_spr;
    bit  cpu_done, resumed;
    reset  = 1'b0;
    req_v  = '0;
    lock_v = '0;
    we_v   = '0;
    g_seen = '0;
    for (int i = 0; i < 3; i++) begin
      addr_v[i] = '0;
      wd_v[i]   = '0;
    end
    for (int i = 0; i < 4096; i++) mem[i] = 8'($urandom);
    mem[12'h200] = 8'h12;
    for (int i = 0; i < 4096; i++) ref_mem[i] = mem[i];
    model_reset();
    @(posedge clk);
    #1;

    // Requests during reset must not be granted.
    req_v = 3'b111;
    cycle_step();
    cycle_step();
    req_v = 3'b000;
    reset = 1'b1;
    cycle_step();
    chk("rst_ram_en", 32'(ram_en), 32'd0);
    chk("rst_ram_we", 32'(ram_we), 32'd0);
    chk("rst_ram_addr", 32'(ram_addr), 32'd0);
    chk("rst_ram_wdata", 32'(ram_wdata), 32'd0);
    chk("rst_rvalid", 32'({ldr_rvalid, spr_rvalid, cpu_rvalid}), 32'd0);
    chk("rst_owner", 32'(owner), 32'd2);

    // Single cpu read of 0x200.
    req_v = 3'b001; we_v = 3'b000; addr_v[0] = 12'h200;
    cycle_step();
    chk("single_gnt", 32'(g_seen), 32'b001);
    req_v = 3'b000;
    chk("single_ram_en", 32'(ram_en), 32'd1);
    chk("single_ram_addr", 32'(ram_addr), 32'h200);
    cycle_step();
    chk("single_rvalid", 32'(cpu_rvalid), 32'd1);
    chk("single_rdata", 32'(rdata), 32'h12);

    // Unlocked rotation from reset: cpu, spr, ldr three times.
    do_reset(2);
    req_v = 3'b111; lock_v = 3'b000; we_v = 3'b000;
    for (int i = 0; i < 9; i++) begin
      cycle_step();
      chk("rot_order", 32'(g_seen), 32'(3'b001 << (i % 3)));
      for (int j = 0; j < 3; j++) if (g_seen[j]) addr_v[j] = 12'($urandom);
    end
    req_v = 3'b000;

    // Lock bound: spr locked burst 0x300..0x313 against a waiting cpu.
    do_reset(2);
    we_v = 3'b000; lock_v = 3'b010; req_v = 3'b010; addr_v[1] = 12'h300;
    n_spr = 0; cpu_done = 0; resumed = 0;
    for (int t = 0; t < 60 && (n_spr < 20 || !cpu_done); t++) begin
      cycle_step();
      if (t == 0) begin
        req_v[0]  = 1'b1;
        addr_v[0] = 12'h123;
      end
      if (g_seen[1]) begin
        n_spr++;
        if (cpu_done && !resumed) begin
          resumed = 1;
          chk("lock_resume_addr", 32'(ram_addr), 32'h310);
        end
        if (n_spr == 20) req_v[1] = 1'b0;
        else begin
          addr_v[1] = 12'(12'h300 + n_spr);
          lock_v[1] = (n_spr < 19);
        end
      end
      if (g_seen[0]) begin
        cpu_done = 1;
        req_v[0] = 1'b0;
        chk("lock_bound_run", 32'(n_spr), 32'd16);
      end
    end
    chk("lock_bound_total", 32'(n_spr), 32'd20);
    chk("lock_bound_cpu", 32'(cpu_done), 32'd1);
    req_v = 3'b000; lock_v = 3'b000;

    // Loader write of 0xAB to 0x3FF, then cpu read of 0x3FF on the next grant.
    req_v = 3'b100; we_v = 3'b100; addr_v[2] = 12'h3FF; wd_v[2] = 8'hAB;
    cycle_step();
    chk("raw_wr_gnt", 32'(g_seen), 32'b100);
    req_v = 3'b001; we_v = 3'b000; addr_v[0] = 12'h3FF;
    cycle_step();
    chk("raw_rd_gnt", 32'(g_seen), 32'b001);
    req_v = 3'b000;
    chk("raw_no_ldr_rvalid", 32'(ldr_rvalid), 32'd0);
    cycle_step();
    chk("raw_rvalid", 32'(cpu_rvalid), 32'd1);
    chk("raw_rdata", 32'(rdata), 32'hAB);

    // Reset in the cycle after a spr read grant drops the read.
    req_v = 3'b010; we_v = 3'b000; addr_v[1] = 12'h250;
    cycle_step();
    chk("mid_gnt", 32'(g_seen), 32'b010);
    req_v = 3'b000;
    reset = 1'b0;
    #1;
    chk("mid_ram_en", 32'(ram_en), 32'd0);
    do_reset(3);
    repeat (3) cycle_step();
    req_v = 3'b111;
    cycle_step();
    chk("mid_first_order", 32'(g_seen), 32'b001);
    req_v = 3'b000;

    // Lock release: cpu holds 3 locked beats, then drops req; spr takes over, cpu not favoured after.
    do_reset(2);
    req_v = 3'b011; lock_v = 3'b001; we_v = 3'b000; addr_v[1] = 12'h500;
    for (int i = 0; i < 3; i++) begin
      addr_v[0] = 12'(12'h400 + i);
      cycle_step();
      chk("rel_hold", 32'(g_seen), 32'b001);
    end
    req_v[0] = 1'b0;
    cycle_step();
    chk("rel_spr_gnt", 32'(g_seen), 32'b010);
    req_v = 3'b101; lock_v = 3'b000;
    cycle_step();
    chk("rel_no_favour", 32'(g_seen), 32'b100);
    req_v[2] = 1'b0;
    cycle_step();
    chk("rel_cpu_after", 32'(g_seen), 32'b001);
    req_v = 3'b000;

    // Randomized traffic on a narrow address window so reads often follow writes.
    for (int t = 0; t < 1500; t++) begin
      if (t == 750) do_reset(2);
      for (int i = 0; i < 3; i++) begin
        if (!req_v[i] || g_seen[i]) begin
          req_v[i]  = ($urandom_range(0, 99) < 75);
          lock_v[i] = ($urandom_range(0, 99) < 85);
          we_v[i]   = (i == 2) ? ($urandom_range(0, 1) == 1) : ($urandom_range(0, 3) == 0);
          addr_v[i] = 12'h3F0 | 12'($urandom_range(0, 15));
          wd_v[i]   = 8'($urandom);
        end
      end
      cycle_step();
    end

    req_v = 3'b000;
    repeat (4) cycle_step();
    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
